matmul_operand_server: RTL and testbench



---
 rtl/matmul_pkg.sv | 31 +++
 rtl/matmul_rr_arbiter.sv | 39 +++
 rtl/matmul_operand_server.sv | 172 +++++++++++++++++
 tb/tb_matmul_operand_server.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply engine and its operand server.
// Provides default word/address widths, the requester encoding used by the
// round-robin pointer, and a helper that advances the pointer A->B->C->A.
package matmul_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 12;
  localparam int unsigned DATA_WIDTH_DEF = 32;
  localparam int unsigned DEPTH_DEF      = 4096;

  // Width of the round-robin pointer (three requesters).
  localparam int unsigned RR_PTR_W = 2;

  typedef enum logic [RR_PTR_W-1:0] {
    REQ_A = 2'd0,
    REQ_B = 2'd1,
    REQ_C = 2'd2
  } req_e;

  // Next requester in round-robin order; the unused code folds back to A.
  function automatic req_e rr_next(input req_e r);
    req_e n;
    unique case (r)
      REQ_A:   n = REQ_B;
      REQ_B:   n = REQ_C;
      REQ_C:   n = REQ_A;
      default: n = REQ_A;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/matmul_rr_arbiter.sv
// 3-way round-robin arbiter (A, B, C) with absolute host override.
// Ports:
//   host_en    - host access this cycle; suppresses all engine grants
//   req_valid  - request valids, indexed by req_e (bit 0 = A, 1 = B, 2 = C)
//   ptr        - current round-robin pointer (highest priority requester)
//   grant      - one-hot grant, indexed by req_e; zero when nothing granted
//   ptr_next   - pointer after this cycle: granted+1, or unchanged
module matmul_rr_arbiter
  import matmul_pkg::*;
(
  input  logic       host_en,
  input  logic [2:0] req_valid,
  input  req_e       ptr,
  output logic [2:0] grant,
  output req_e       ptr_next
);

  req_e cand;
  logic found;

  always_comb begin
    grant    = 3'b000;
    ptr_next = ptr;
    found    = 1'b0;
    // Normalise an illegal pointer code to A so indexing stays in range.
    cand     = (ptr > REQ_C) ? REQ_A : ptr;
    if (!host_en) begin
      for (int i = 0; i < 3; i++) begin
        if (!found && req_valid[cand]) begin
          grant[cand] = 1'b1;
          ptr_next    = rr_next(cand);
          found       = 1'b1;
        end
        cand = rr_next(cand);
      end
    end
  end

endmodule

// File: rtl/matmul_operand_server.sv
// Operand server for the matrix-multiply engine: a single-ported word
// scratchpad holding A, B and C. One access per cycle; the host port has
// absolute priority, otherwise A reads, B reads and C writes share the port
// round-robin. Reads return registered data one cycle after the transfer.
// Out-of-range addresses (>= DEPTH) read as 0 and drop writes.
// Optional feature macro: MATMUL_OPERAND_SERVER_ERR_EN adds a sticky err flag
// set by any out-of-range transfer; without it err is tied to 0.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   host_*                   - host read/write port, always accepted
//   a_req_*/a_rsp_*          - A operand read request / response
//   b_req_*/b_rsp_*          - B operand read request / response
//   c_wr_*                   - C result write request
//   err                      - sticky out-of-range flag
module matmul_operand_server
  import matmul_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned DEPTH      = DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  host_en,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  input  logic                  a_req_valid,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  output logic                  a_req_ready,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_data,
  input  logic                  b_req_valid,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  output logic                  b_req_ready,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_data,
  input  logic                  c_wr_valid,
  input  logic [ADDR_WIDTH-1:0] c_wr_addr,
  input  logic [DATA_WIDTH-1:0] c_wr_data,
  output logic                  c_wr_ready,
  output logic                  err
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  req_e ptr_q, ptr_d;
  logic [2:0] req_valid;
  logic [2:0] grant;

  logic                  acc_valid;
  logic                  acc_we;
  logic [ADDR_WIDTH-1:0] acc_addr;
  logic [DATA_WIDTH-1:0] acc_wdata;
  logic [IdxW-1:0]       acc_idx;
  logic                  in_range;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  host_rvalid_q, host_rvalid_d;
  logic [DATA_WIDTH-1:0] host_rdata_q, host_rdata_d;
  logic                  a_rsp_valid_q, a_rsp_valid_d;
  logic [DATA_WIDTH-1:0] a_rsp_data_q, a_rsp_data_d;
  logic                  b_rsp_valid_q, b_rsp_valid_d;
  logic [DATA_WIDTH-1:0] b_rsp_data_q, b_rsp_data_d;

  assign req_valid = {c_wr_valid, b_req_valid, a_req_valid};

  matmul_rr_arbiter u_arb (
    .host_en   (host_en),
    .req_valid (req_valid),
    .ptr       (ptr_q),
    .grant     (grant),
    .ptr_next  (ptr_d)
  );

  assign a_req_ready = grant[REQ_A];
  assign b_req_ready = grant[REQ_B];
  assign c_wr_ready  = grant[REQ_C];

  // Select the single memory access for this cycle.
  always_comb begin
    acc_valid = host_en | (|grant);
    acc_we    = 1'b0;
    acc_addr  = a_req_addr;
    acc_wdata = c_wr_data;
    if (host_en) begin
      acc_we    = host_we;
      acc_addr  = host_addr;
      acc_wdata = host_wdata;
    end else if (grant[REQ_C]) begin
      acc_we    = 1'b1;
      acc_addr  = c_wr_addr;
    end else if (grant[REQ_B]) begin
      acc_addr  = b_req_addr;
    end
  end

  // Extra MSB keeps the compare exact when DEPTH == 2**ADDR_WIDTH.
  assign in_range = ({1'b0, acc_addr} < (ADDR_WIDTH + 1)'(DEPTH));
  assign acc_idx  = acc_addr[IdxW-1:0];
  assign mem_we   = acc_valid & acc_we & in_range;
  assign rd_data  = in_range ? mem_q[acc_idx] : '0;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[acc_idx] <= acc_wdata;
    end
  end

  // Response next-state: data registers hold while no response is issued.
  always_comb begin
    host_rvalid_d = host_en & ~host_we;
    host_rdata_d  = host_rvalid_d ? rd_data : host_rdata_q;
    a_rsp_valid_d = grant[REQ_A];
    a_rsp_data_d  = a_rsp_valid_d ? rd_data : a_rsp_data_q;
    b_rsp_valid_d = grant[REQ_B];
    b_rsp_data_d  = b_rsp_valid_d ? rd_data : b_rsp_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q         <= REQ_A;
      host_rvalid_q <= 1'b0;
      host_rdata_q  <= '0;
      a_rsp_valid_q <= 1'b0;
      a_rsp_data_q  <= '0;
      b_rsp_valid_q <= 1'b0;
      b_rsp_data_q  <= '0;
    end else begin
      ptr_q         <= ptr_d;
      host_rvalid_q <= host_rvalid_d;
      host_rdata_q  <= host_rdata_d;
      a_rsp_valid_q <= a_rsp_valid_d;
      a_rsp_data_q  <= a_rsp_data_d;
      b_rsp_valid_q <= b_rsp_valid_d;
      b_rsp_data_q  <= b_rsp_data_d;
    end
  end

  assign host_rvalid = host_rvalid_q;
  assign host_rdata  = host_rdata_q;
  assign a_rsp_valid = a_rsp_valid_q;
  assign a_rsp_data  = a_rsp_data_q;
  assign b_rsp_valid = b_rsp_valid_q;
  assign b_rsp_data  = b_rsp_data_q;

`ifdef MATMUL_OPERAND_SERVER_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q | (acc_valid & ~in_range);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_operand_server.sv
// Directed self-checking bench for matmul_operand_server (DEPTH = 16 so the
// out-of-range path is reachable). Inputs change 1 time unit after a rising
// edge; combinational readies are checked 1 unit later, registered outputs
// 1 unit after the next rising edge.
module tb_matmul_operand_server;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 16;

`ifdef MATMUL_OPERAND_SERVER_ERR_EN
  localparam logic ERR_EXP = 1'b1;
`else
  localparam logic ERR_EXP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          host_en, host_we;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          a_req_valid, a_req_ready, a_rsp_valid;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_rsp_data;
  logic          b_req_valid, b_req_ready, b_rsp_valid;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_rsp_data;
  logic          c_wr_valid, c_wr_ready;
  logic [AW-1:0] c_wr_addr;
  logic [DW-1:0] c_wr_data;
  logic          err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  matmul_operand_server #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .host_en     (host_en),
    .host_we     (host_we),
    .host_addr   (host_addr),
    .host_wdata  (host_wdata),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .a_req_valid (a_req_valid),
    .a_req_addr  (a_req_addr),
    .a_req_ready (a_req_ready),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_data  (a_rsp_data),
    .b_req_valid (b_req_valid),
    .b_req_addr  (b_req_addr),
    .b_req_ready (b_req_ready),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_data  (b_rsp_data),
    .c_wr_valid  (c_wr_valid),
    .c_wr_addr   (c_wr_addr),
    .c_wr_data   (c_wr_data),
    .c_wr_ready  (c_wr_ready),
    .err         (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_en = 0; host_we = 0; host_addr = '0; host_wdata = '0;
    a_req_valid = 0; a_req_addr = '0;
    b_req_valid = 0; b_req_addr = '0;
    c_wr_valid = 0; c_wr_addr = '0; c_wr_data = '0;
  endtask

  task automatic test_reset();
    rst = 1;
    idle_inputs();
    step();
    step();
    if ({host_rvalid, a_rsp_valid, b_rsp_valid, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_valids: got %b want 0000", {host_rvalid, a_rsp_valid, b_rsp_valid, err});
    end
    checks++;
    if ({host_rdata, a_rsp_data, b_rsp_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: got %h %h %h want 0", host_rdata, a_rsp_data, b_rsp_data);
    end
    checks++;
    rst = 0;
  endtask

  task automatic test_host();
    host_en = 1; host_we = 1; host_addr = 5; host_wdata = 32'h11;
    step();
    host_addr = 6; host_wdata = 32'h22;
    step();
    host_we = 0; host_addr = 5;
    step();
    host_en = 0;
    if (host_rvalid !== 1'b1 || host_rdata !== 32'h11) begin
      errors++;
      $display("FAIL host_read: got v=%b d=%h want v=1 d=00000011", host_rvalid, host_rdata);
    end
    checks++;
    step();
    if (host_rvalid !== 1'b0 || host_rdata !== 32'h11) begin
      errors++;
      $display("FAIL host_hold: got v=%b d=%h want v=0 d=00000011", host_rvalid, host_rdata);
    end
    checks++;
  endtask

  // Pointer is A on entry; A then B, pointer ends at C.
  task automatic test_ab();
    a_req_valid = 1; a_req_addr = 5;
    b_req_valid = 1; b_req_addr = 6;
    #1;
    if ({a_req_ready, b_req_ready, c_wr_ready} !== 3'b100) begin
      errors++;
      $display("FAIL ab_grant0: got %b want 100", {a_req_ready, b_req_ready, c_wr_ready});
    end
    checks++;
    step();
    a_req_valid = 0;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h11 || b_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ab_arsp: got av=%b ad=%h bv=%b want 1 00000011 0", a_rsp_valid, a_rsp_data,
               b_rsp_valid);
    end
    checks++;
    #1;
    if (b_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL ab_grant1: got b_ready=%b want 1", b_req_ready);
    end
    checks++;
    step();
    b_req_valid = 0;
    if (b_rsp_valid !== 1'b1 || b_rsp_data !== 32'h22 || a_rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL ab_brsp: got bv=%b bd=%h av=%b want 1 00000022 0", b_rsp_valid, b_rsp_data,
               a_rsp_valid);
    end
    checks++;
    // Pointer at C: with all three asking, C must win.
    a_req_valid = 1; b_req_valid = 1; c_wr_valid = 1; c_wr_addr = 10; c_wr_data = 32'h1234;
    #1;
    if ({a_req_ready, b_req_ready, c_wr_ready} !== 3'b001) begin
      errors++;
      $display("FAIL ab_ptr_c: got %b want 001", {a_req_ready, b_req_ready, c_wr_ready});
    end
    checks++;
    idle_inputs();
  endtask

  // Pointer C on entry: C write, then A read of the same address.
  task automatic test_raw();
    c_wr_valid = 1; c_wr_addr = 9; c_wr_data = 32'hDEAD;
    #1;
    if (c_wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_cgrant: got %b want 1", c_wr_ready);
    end
    checks++;
    step();
    c_wr_valid = 0;
    a_req_valid = 1; a_req_addr = 9;
    #1;
    if (a_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL raw_agrant: got %b want 1", a_req_ready);
    end
    checks++;
    step();
    a_req_valid = 0;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'hDEAD) begin
      errors++;
      $display("FAIL raw_data: got v=%b d=%h want v=1 d=0000dead", a_rsp_valid, a_rsp_data);
    end
    checks++;
  endtask

  // Pointer B on entry; all three held valid for 6 cycles.
  task automatic test_rr();
    logic [2:0] exp_seq [6];
    exp_seq = '{3'b010, 3'b001, 3'b100, 3'b010, 3'b001, 3'b100};
    a_req_valid = 1; a_req_addr = 5;
    b_req_valid = 1; b_req_addr = 6;
    c_wr_valid = 1; c_wr_addr = 10; c_wr_data = 32'h1234;
    for (int i = 0; i < 6; i++) begin
      #1;
      if ({a_req_ready, b_req_ready, c_wr_ready} !== exp_seq[i]) begin
        errors++;
        $display("FAIL rr_cycle%0d: got %b want %b", i, {a_req_ready, b_req_ready, c_wr_ready},
                 exp_seq[i]);
      end
      checks++;
      step();
    end
    idle_inputs();
  endtask

  // Pointer B on entry; host cycle blocks all, then B resumes.
  task automatic test_host_override();
    a_req_valid = 1; a_req_addr = 5;
    b_req_valid = 1; b_req_addr = 6;
    c_wr_valid = 1; c_wr_addr = 10; c_wr_data = 32'h1234;
    host_en = 1; host_we = 0; host_addr = 9;
    #1;
    if ({a_req_ready, b_req_ready, c_wr_ready} !== 3'b000) begin
      errors++;
      $display("FAIL ovr_block: got %b want 000", {a_req_ready, b_req_ready, c_wr_ready});
    end
    checks++;
    step();
    host_en = 0;
    if (host_rvalid !== 1'b1 || host_rdata !== 32'hDEAD) begin
      errors++;
      $display("FAIL ovr_hread: got v=%b d=%h want v=1 d=0000dead", host_rvalid, host_rdata);
    end
    checks++;
    #1;
    if ({a_req_ready, b_req_ready, c_wr_ready} !== 3'b010) begin
      errors++;
      $display("FAIL ovr_resume: got %b want 010", {a_req_ready, b_req_ready, c_wr_ready});
    end
    checks++;
    step();
    idle_inputs();
  endtask

  // Pointer C on entry; lone A request is granted.
  task automatic test_oor();
    a_req_valid = 1; a_req_addr = 20;
    step();
    a_req_valid = 0;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h0 || err !== ERR_EXP) begin
      errors++;
      $display("FAIL oor_read: got v=%b d=%h err=%b want v=1 d=0 err=%b", a_rsp_valid, a_rsp_data,
               err, ERR_EXP);
    end
    checks++;
    // Out-of-range write must not alias onto address 5.
    host_en = 1; host_we = 1; host_addr = 21; host_wdata = 32'hBAD;
    step();
    host_we = 0; host_addr = 5;
    step();
    host_en = 0;
    if (host_rdata !== 32'h11 || err !== ERR_EXP) begin
      errors++;
      $display("FAIL oor_alias: got d=%h err=%b want d=00000011 err=%b", host_rdata, err, ERR_EXP);
    end
    checks++;
    host_en = 1; host_addr = 21;
    step();
    host_en = 0;
    if (host_rdata !== 32'h0) begin
      errors++;
      $display("FAIL oor_hread: got %h want 0", host_rdata);
    end
    checks++;
    step();
    step();
    if (err !== ERR_EXP) begin
      errors++;
      $display("FAIL oor_sticky: got %b want %b", err, ERR_EXP);
    end
    checks++;
  endtask

  // A transfer in the reset cycle yields no response; state returns to reset.
  task automatic test_reset_midop();
    a_req_valid = 1; a_req_addr = 5;
    rst = 1;
    step();
    rst = 0;
    a_req_valid = 0;
    if (a_rsp_valid !== 1'b0 || a_rsp_data !== 32'h0 || err !== 1'b0) begin
      errors++;
      $display("FAIL rst_drop: got v=%b d=%h err=%b want 0 0 0", a_rsp_valid, a_rsp_data, err);
    end
    checks++;
    a_req_valid = 1; b_req_valid = 1; c_wr_valid = 1; c_wr_addr = 11;
    #1;
    if ({a_req_ready, b_req_ready, c_wr_ready} !== 3'b100) begin
      errors++;
      $display("FAIL rst_ptr: got %b want 100", {a_req_ready, b_req_ready, c_wr_ready});
    end
    checks++;
    step();
    idle_inputs();
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h11) begin
      errors++;
      $display("FAIL rst_rearb: got v=%b d=%h want v=1 d=00000011", a_rsp_valid, a_rsp_data);
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_host();
    test_ab();
    test_raw();
    test_rr();
    test_host_override();
    test_oor();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
